// File: rtl/fp_unpack_pipe.sv
// Floating-point operand unpacker for the MAC front end: splits two operands into
// sign / effective exponent / significand / class, behind a valid-ready skid stage.
module fp_unpack_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a_in,
    input  logic [EXP_W+MAN_W:0]     b_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sign_a,
    output logic                     sign_b,
    output logic [EXP_W-1:0]         exp_a,
    output logic [EXP_W-1:0]         exp_b,
    output logic [MAN_W:0]           sig_a,
    output logic [MAN_W:0]           sig_b,
    output logic [3:0]               cls_a,
    output logic [3:0]               cls_b,
    output logic                     nan_seen,
    input  logic                     nan_clr,
    output logic [CNT_W-1:0]         beat_cnt
);

    localparam int OP_W  = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int DEC_W = 1 + EXP_W + SIG_W + 4;
    localparam int PAY_W = 2 * DEC_W;

    localparam logic [3:0] CLS_NORMAL = 4'b0000;
    localparam logic [3:0] CLS_ZERO   = 4'b0001;
    localparam logic [3:0] CLS_SUB    = 4'b0010;
    localparam logic [3:0] CLS_INF    = 4'b0100;
    localparam logic [3:0] CLS_NAN    = 4'b1000;

    logic [OP_W-1:0]  op_in   [2];
    logic [DEC_W-1:0] dec     [2];
    logic [1:0]       dec_nan;

    assign op_in[0] = a_in;
    assign op_in[1] = b_in;

    // Per-operand field decode; subnormals report exponent 1 so the multiplier
    // can treat every finite operand uniformly as sig * 2^(exp-bias).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            logic             sgn;
            logic [EXP_W-1:0] e;
            logic [MAN_W-1:0] m;
            logic             e_zero;
            logic             e_ones;
            logic             m_zero;
            logic [EXP_W-1:0] exp_d;
            logic [SIG_W-1:0] sig_d;
            logic [3:0]       cls_d;

            assign {sgn, e, m} = op_in[gi];
            assign e_zero = (e == '0);
            assign e_ones = (e == '1);
            assign m_zero = (m == '0);

            always_comb begin
                exp_d = e;
                sig_d = {1'b1, m};
                cls_d = CLS_NORMAL;
                if (e_zero) begin
                    if (m_zero) begin
                        exp_d = '0;
                        sig_d = '0;
                        cls_d = CLS_ZERO;
                    end else begin
                        exp_d = EXP_W'(1);
                        sig_d = {1'b0, m};
                        cls_d = CLS_SUB;
                    end
                end else if (e_ones) begin
                    cls_d = m_zero ? CLS_INF : CLS_NAN;
                end
            end

            assign dec[gi]     = {sgn, exp_d, sig_d, cls_d};
            assign dec_nan[gi] = cls_d[3];
        end
    endgenerate

    logic [PAY_W-1:0] beat_dec;
    assign beat_dec = {dec[0], dec[1]};

    logic [PAY_W-1:0] main_reg,  main_next;
    logic             main_valid_reg, main_valid_next;
    logic [PAY_W-1:0] skid_reg,  skid_next;
    logic             skid_full_reg, skid_full_next;
    logic             nan_seen_reg, nan_seen_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic accept;
    logic drain;

    assign in_ready = !skid_full_reg;
    assign accept   = in_valid && !skid_full_reg;
    assign drain    = main_valid_reg && out_ready;

    // Skid is only ever filled while main is held, so accept and skid_full
    // are mutually exclusive and a drain never has two sources to choose from.
    always_comb begin
        main_next       = main_reg;
        main_valid_next = main_valid_reg;
        skid_next       = skid_reg;
        skid_full_next  = skid_full_reg;
        if (drain) begin
            if (skid_full_reg) begin
                main_next      = skid_reg;
                skid_full_next = 1'b0;
            end else if (accept) begin
                main_next = beat_dec;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_reg) begin
                main_next       = beat_dec;
                main_valid_next = 1'b1;
            end else begin
                skid_next      = beat_dec;
                skid_full_next = 1'b1;
            end
        end
    end

    always_comb begin
        nan_seen_next = nan_seen_reg;
        if (nan_clr) begin
            nan_seen_next = 1'b0;
        end
        if (accept && (|dec_nan)) begin
            nan_seen_next = 1'b1;
        end
    end

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        if (drain) begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_reg       <= '0;
            skid_full_reg  <= 1'b0;
            nan_seen_reg   <= 1'b0;
            beat_cnt_reg   <= '0;
        end else begin
            main_reg       <= main_next;
            main_valid_reg <= main_valid_next;
            skid_reg       <= skid_next;
            skid_full_reg  <= skid_full_next;
            nan_seen_reg   <= nan_seen_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

    assign out_valid = main_valid_reg;
    assign nan_seen  = nan_seen_reg;
    assign beat_cnt  = beat_cnt_reg;
    assign {sign_a, exp_a, sig_a, cls_a} = main_reg[PAY_W-1 -: DEC_W];
    assign {sign_b, exp_b, sig_b, cls_b} = main_reg[DEC_W-1:0];

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Directed and randomized checks of fp_unpack_pipe (FP16 instance plus an FP32 instance).
module tb_fp_unpack_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, nan_clr, nan_seen;
    logic [15:0] a_in, b_in, beat_cnt;
    logic        sign_a, sign_b;
    logic [4:0]  exp_a, exp_b;
    logic [10:0] sig_a, sig_b;
    logic [3:0]  cls_a, cls_b;

    logic        in_valid32, in_ready32, out_valid32, nan_seen32;
    logic [31:0] a32, b32;
    logic        sign_a32, sign_b32;
    logic [7:0]  exp_a32, exp_b32;
    logic [23:0] sig_a32, sig_b32;
    logic [3:0]  cls_a32, cls_b32;
    logic [15:0] beat_cnt32;

    int n_checks = 0;
    int n_fail   = 0;

    logic [41:0] model_q [$];
    logic        model_nan;
    logic [15:0] model_cnt;

    always #5 clk = ~clk;

    fp_unpack_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
        .sig_a(sig_a), .sig_b(sig_b), .cls_a(cls_a), .cls_b(cls_b),
        .nan_seen(nan_seen), .nan_clr(nan_clr), .beat_cnt(beat_cnt)
    );

    fp_unpack_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a_in(a32), .b_in(b32), .out_valid(out_valid32), .out_ready(1'b1),
        .sign_a(sign_a32), .sign_b(sign_b32), .exp_a(exp_a32), .exp_b(exp_b32),
        .sig_a(sig_a32), .sig_b(sig_b32), .cls_a(cls_a32), .cls_b(cls_b32),
        .nan_seen(nan_seen32), .nan_clr(1'b0), .beat_cnt(beat_cnt32)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    // Reference FP16 decode: {sign, exp5, sig11, cls4}
    function automatic logic [20:0] model_dec(input logic [15:0] x);
        logic [4:0] e;
        logic [9:0] m;
        e = x[14:10];
        m = x[9:0];
        case (e)
            5'd0:    return (m == 0) ? {x[15], 5'd0, 11'd0, 4'b0001}
                                     : {x[15], 5'd1, 1'b0, m, 4'b0010};
            5'd31:   return (m == 0) ? {x[15], 5'd31, 11'h400, 4'b0100}
                                     : {x[15], 5'd31, 1'b1, m, 4'b1000};
            default: return {x[15], e, 1'b1, m, 4'b0000};
        endcase
    endfunction

    function automatic logic [41:0] observed();
        return {sign_a, exp_a, sig_a, cls_a, sign_b, exp_b, sig_b, cls_b};
    endfunction

    // One clock: score the handshakes implied by the current inputs, then check state after the edge.
    task automatic tick();
        logic acc, drn;
        logic [41:0] req;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (drn) begin
            if (model_q.size() == 0) begin
                check_eq("unexpected_beat", 64'(observed()), 64'h0);
            end else begin
                req = model_q.pop_front();
                check_eq("beat_data", 64'(observed()), 64'(req));
            end
            model_cnt = model_cnt + 16'd1;
        end
        if (nan_clr) model_nan = 1'b0;
        if (acc) begin
            model_q.push_back({model_dec(a_in), model_dec(b_in)});
            if (model_dec(a_in)[3] || model_dec(b_in)[3]) model_nan = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("nan_seen_model", 64'(nan_seen), 64'(model_nan));
        check_eq("beat_cnt_model", 64'(beat_cnt), 64'(model_cnt));
    endtask

    task automatic model_reset();
        model_q.delete();
        model_nan = 1'b0;
        model_cnt = 16'd0;
    endtask

    initial begin
        int idx, budget, accepted, base;
        logic [15:0] x;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; nan_clr = 1'b0;
        a_in = '0; b_in = '0; in_valid32 = 1'b0; a32 = '0; b32 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        check_eq("rst_payload", 64'(observed()), 64'd0);

        // Normal / zero decode, plus the FP32 instance alongside
        in_valid = 1'b1; a_in = 16'h3C00; b_in = 16'h8000; out_ready = 1'b1;
        in_valid32 = 1'b1; a32 = 32'h3F80_0000; b32 = 32'hFF80_0000;
        tick();
        in_valid32 = 1'b0;
        check_eq("lat1_out_valid", 64'(out_valid), 64'd1);
        check_eq("a_norm", 64'({sign_a, exp_a, sig_a, cls_a}), 64'({1'b0, 5'd15, 11'h400, 4'b0000}));
        check_eq("b_zero", 64'({sign_b, exp_b, sig_b, cls_b}), 64'({1'b1, 5'd0, 11'h000, 4'b0001}));
        check_eq("nan_idle", 64'(nan_seen), 64'd0);
        check_eq("fp32_valid", 64'(out_valid32), 64'd1);
        check_eq("fp32_a", 64'({sign_a32, exp_a32, sig_a32, cls_a32}), 64'({1'b0, 8'd127, 24'h800000, 4'b0000}));
        check_eq("fp32_b_inf", 64'({sign_b32, exp_b32, sig_b32, cls_b32}), 64'({1'b1, 8'd255, 24'h800000, 4'b0100}));

        // Subnormal / infinity
        a_in = 16'h0001; b_in = 16'h7C00;
        tick();
        check_eq("a_sub", 64'({exp_a, sig_a, cls_a}), 64'({5'd1, 11'h001, 4'b0010}));
        check_eq("b_inf", 64'({exp_b, sig_b, cls_b}), 64'({5'd31, 11'h400, 4'b0100}));
        check_eq("cnt_after_1", 64'(beat_cnt), 64'd1);

        // NaN sets sticky flag; set wins over a simultaneous clear
        a_in = 16'h7E00; b_in = 16'h3C00;
        tick();
        check_eq("a_nan_cls", 64'(cls_a), 64'(4'b1000));
        check_eq("nan_set", 64'(nan_seen), 64'd1);
        a_in = 16'hFE01; nan_clr = 1'b1;
        tick();
        check_eq("nan_set_wins", 64'(nan_seen), 64'd1);
        check_eq("nan_sign_kept", 64'({sign_a, sig_a}), 64'({1'b1, 11'h601}));
        in_valid = 1'b0;
        tick();
        nan_clr = 1'b0;
        check_eq("nan_cleared", 64'(nan_seen), 64'd0);
        check_eq("drained_empty", 64'(out_valid), 64'd0);

        // Backpressure: two beats held, in_ready drops from cycle 2
        out_ready = 1'b0;
        in_valid = 1'b1; a_in = 16'h4000; b_in = 16'hC000;
        tick();
        check_eq("bp_c1_in_ready", 64'(in_ready), 64'd1);
        a_in = 16'h4001; b_in = 16'hC010;
        tick();
        check_eq("bp_c2_in_ready", 64'(in_ready), 64'd0);
        a_in = 16'h4002; b_in = 16'hC020;
        tick();
        check_eq("bp_hold_in_ready", 64'(in_ready), 64'd0);
        check_eq("bp_hold_main", 64'({out_valid, sig_a, sig_b}), 64'({1'b1, 11'h400, 11'h400}));
        out_ready = 1'b1;
        idx = 2;
        budget = 0;
        while (idx < 5 && budget < 50) begin
            a_in = 16'h4000 | 16'(idx); b_in = 16'hC000 | 16'(idx << 4);
            if (in_ready) idx++;
            tick();
            budget++;
        end
        in_valid = 1'b0;
        budget = 0;
        while (model_q.size() != 0 && budget < 50) begin
            tick();
            budget++;
        end
        check_eq("bp_all_drained", 64'(model_q.size()), 64'd0);
        check_eq("bp_beat_cnt", 64'(beat_cnt), 64'd9);

        // Reset mid-stream with skid full
        out_ready = 1'b0; in_valid = 1'b1;
        a_in = 16'h7E00; b_in = 16'h0000;
        tick();
        a_in = 16'h7E01;
        tick();
        check_eq("pre_rst_full", 64'({in_ready, out_valid, nan_seen}), 64'({1'b0, 1'b1, 1'b1}));
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready), 64'd1);
        check_eq("arst_beat_cnt", 64'(beat_cnt), 64'd0);
        check_eq("arst_nan", 64'(nan_seen), 64'd0);
        check_eq("arst_payload", 64'(observed()), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1; out_ready = 1'b1; a_in = 16'h3C00; b_in = 16'h0001;
        tick();
        check_eq("post_rst_valid", 64'(out_valid), 64'd1);
        check_eq("post_rst_data", 64'({exp_a, cls_a, exp_b, cls_b}), 64'({5'd15, 4'b0000, 5'd1, 4'b0010}));
        in_valid = 1'b0;
        tick();

        // Random valid/ready traffic against the model
        base = int'(model_cnt);
        accepted = 0;
        budget = 0;
        while (accepted < 1000 && budget < 20000) begin
            x = 16'($urandom);
            case ($urandom_range(3))
                0: x[14:10] = 5'd0;
                1: x[14:10] = 5'd31;
                default: ;
            endcase
            if ($urandom_range(3) == 0) x[9:0] = 10'd0;
            a_in = x;
            b_in = 16'($urandom);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            nan_clr   = ($urandom_range(15) == 0);
            if (in_valid && in_ready) accepted++;
            tick();
            budget++;
        end
        check_eq("rand_accept_budget", 64'(accepted), 64'd1000);
        in_valid = 1'b0; out_ready = 1'b1; nan_clr = 1'b0;
        budget = 0;
        while (model_q.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        check_eq("rand_drained", 64'(model_q.size()), 64'd0);
        check_eq("rand_beat_cnt", 64'(beat_cnt), 64'(16'(base + 1000)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
